// File: rtl/ring_pkg.sv
// Shared ring definitions: slot-type encodings, ring field widths and the
// local token arbiter's state encoding.
package ring_pkg;

    localparam int unsigned PayloadW = 32;
    localparam int unsigned TypeW    = 4;
    localparam int unsigned SourceW  = 4;
    localparam int unsigned LenW     = 4;

    typedef enum logic [TypeW-1:0] {
        SlotEmpty   = 4'h0,
        SlotBarrier = 4'h1,
        SlotMessage = 4'h2,
        SlotLock    = 4'h3
    } slot_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StWaitToken,
        StDrive
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr,
// wrapping past NCLIENTS-1 back to 0.
module rr_pick #(
    parameter int unsigned NCLIENTS = 4,
    parameter int unsigned IW       = $clog2(NCLIENTS)
) (
    input  logic [NCLIENTS-1:0] want,
    input  logic [IW-1:0]       ptr,
    output logic [IW-1:0]       winner,
    output logic                valid
);

    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned k = 0; k < NCLIENTS; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NCLIENTS) begin
                idx = idx - NCLIENTS;
            end
            if (!valid && want[IW'(idx)]) begin
                valid  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/ring_token_arbiter.sv
// Shares the node's ring token among local clients: round-robin pick, one token
// request per burst, and muxing of the winner's slots onto the ring.
module ring_token_arbiter
    import ring_pkg::*;
#(
    parameter  int unsigned NCLIENTS = 4,
    localparam int unsigned IW       = $clog2(NCLIENTS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SourceW-1:0]           whichCore,
    input  logic [NCLIENTS-1:0]          clientWant,
    input  logic [LenW*NCLIENTS-1:0]     clientLen,
    input  logic [PayloadW*NCLIENTS-1:0] clientRingOut,
    input  logic [TypeW*NCLIENTS-1:0]    clientSlotType,
    output logic [NCLIENTS-1:0]          clientGrant,
    output logic                         ringWantsToken,
    input  logic                         ringAcquireToken,
    output logic                         ringDriveRing,
    output logic [PayloadW-1:0]          ringOut,
    output logic [TypeW-1:0]             ringSlotTypeOut,
    output logic [SourceW-1:0]           ringSourceOut,
    output logic                         ringReleaseToken
);

    arb_state_e      state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   winner_q;
    logic [LenW-1:0] remaining_q;

    logic [IW-1:0]   pick_winner;
    logic            pick_valid;
    logic [LenW-1:0] pick_len;
    logic [IW-1:0]   next_ptr;
    logic            drive;
    logic            last_slot;

    rr_pick #(
        .NCLIENTS (NCLIENTS),
        .IW       (IW)
    ) u_rr_pick (
        .want   (clientWant),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign pick_len  = clientLen[int'(pick_winner)*LenW +: LenW];
    assign next_ptr  = (winner_q == IW'(NCLIENTS - 1)) ? '0 : winner_q + 1'b1;
    // First slot goes out in the acquire cycle itself, so drive is not purely state.
    assign drive     = (state_q == StDrive) || ((state_q == StWaitToken) && ringAcquireToken);
    assign last_slot = (remaining_q == LenW'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            winner_q    <= '0;
            remaining_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        winner_q    <= pick_winner;
                        remaining_q <= (pick_len == '0) ? LenW'(1) : pick_len;
                        state_q     <= StWaitToken;
                    end
                end
                StWaitToken: begin
                    if (ringAcquireToken) begin
                        remaining_q <= remaining_q - LenW'(1);
                        if (last_slot) begin
                            state_q <= StIdle;
                            ptr_q   <= next_ptr;
                        end else begin
                            state_q <= StDrive;
                        end
                    end
                end
                StDrive: begin
                    remaining_q <= remaining_q - LenW'(1);
                    if (last_slot) begin
                        state_q <= StIdle;
                        ptr_q   <= next_ptr;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        clientGrant      = '0;
        ringOut          = '0;
        ringSlotTypeOut  = '0;
        ringSourceOut    = '0;
        ringDriveRing    = drive;
        ringReleaseToken = drive && last_slot;
        ringWantsToken   = (state_q == StWaitToken);
        if (drive) begin
            clientGrant[winner_q] = 1'b1;
            ringOut               = clientRingOut[int'(winner_q)*PayloadW +: PayloadW];
            ringSlotTypeOut       = clientSlotType[int'(winner_q)*TypeW +: TypeW];
            ringSourceOut         = whichCore;
        end
    end

endmodule
